// File: rtl/cmd_resp_tx_pkg.sv
// -----------------------------------------------------------------------------
// cmd_resp_tx_pkg
//   Shared definitions for the UART command path: command and ack codes, the
//   default matched-string length, the response serializer state encoding, and
//   a helper that computes the frame length of a response record.
//   Optional feature macro: RESP_CHECKSUM_EN (adds one trailing XOR byte).
// -----------------------------------------------------------------------------
package cmd_resp_tx_pkg;

   // command codes (cmd_parser side)
   localparam logic [7:0] CMD_SET_HASH = 8'h01;
   localparam logic [7:0] CMD_SEND_STR = 8'h02;

   // ack / status codes
   localparam logic [7:0] ACK_OK       = 8'h01;
   localparam logic [7:0] ACK_MATCH    = 8'h02;

   // "The quick brown fox"
   localparam int unsigned STR_BYTES_DEF = 19;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SEND  = 2'd1,
      S_GUARD = 2'd2,
      S_WAIT  = 2'd3
   } resp_state_t;

   // Number of bytes in a frame: code only, or code + 2-byte position + string,
   // plus the trailing checksum byte when enabled.
   function automatic logic [7:0] frame_len(input logic has_pl,
                                            input int unsigned str_bytes);
      logic [7:0] n;
      n = has_pl ? 8'(3 + str_bytes) : 8'd1;
`ifdef RESP_CHECKSUM_EN
      n = n + 8'd1;
`endif
      return n;
   endfunction

endpackage

// File: rtl/cmd_resp_tx.sv
// -----------------------------------------------------------------------------
// cmd_resp_tx
//   Response serializer for the UART command path. Accepts one response record
//   (code, optional match position + matched string) and emits it as a byte
//   frame over the uart_tx start/busy handshake.
//
//   Ports
//     clk, reset            clock, asynchronous active-high reset
//     resp_valid/ready      record handshake; ready is high only when idle
//     resp_code             first byte of the frame
//     resp_has_payload      append resp_pos (MSB first) and resp_str (MSB byte first)
//     resp_pos, resp_str    payload fields
//     txd_busy              uart_tx busy
//     txd_start, txd_data   one-cycle start strobe and the byte to send
//     resp_done             one-cycle pulse once the last byte has been handed off
//
//   Parameters
//     STR_BYTES      string bytes per payload frame (<= 250, 8-bit byte counter)
//     GUARD_CYCLES   cycles after a start pulse before busy is trusted (>= 1)
//
//   Optional feature macro: RESP_CHECKSUM_EN appends the XOR of all preceding
//   frame bytes as a trailing byte.
// -----------------------------------------------------------------------------
module cmd_resp_tx
   import cmd_resp_tx_pkg::*;
#(
   parameter int unsigned STR_BYTES    = STR_BYTES_DEF,
   parameter int unsigned GUARD_CYCLES = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   resp_valid,
   output logic                   resp_ready,
   input  logic [7:0]             resp_code,
   input  logic                   resp_has_payload,
   input  logic [15:0]            resp_pos,
   input  logic [8*STR_BYTES-1:0] resp_str,
   input  logic                   txd_busy,
   output logic                   txd_start,
   output logic [7:0]             txd_data,
   output logic                   resp_done
);

   localparam int unsigned BUF_W = 8 * (3 + STR_BYTES);

   resp_state_t      state_q;
   logic [BUF_W-1:0] buf_q;
   logic [7:0]       cnt_q;
   logic [7:0]       guard_q;
   logic             txd_start_q;
   logic [7:0]       txd_data_q;
   logic             done_q;

   logic [BUF_W-1:0] cap_d;
   logic [7:0]       len_d;
   logic [7:0]       byte_d;

`ifdef RESP_CHECKSUM_EN
   logic [7:0]       csum_q;
`endif

   assign resp_ready = (state_q == S_IDLE);
   assign txd_start  = txd_start_q;
   assign txd_data   = txd_data_q;
   assign resp_done  = done_q;

   // Capture image: the byte to send next always sits in the top byte.
   always_comb begin
      cap_d = '0;
      if (resp_has_payload)
         cap_d = {resp_code, resp_pos, resp_str};
      else
         cap_d[BUF_W-1 -: 8] = resp_code;
      len_d = frame_len(resp_has_payload, STR_BYTES);
   end

   always_comb begin
      byte_d = buf_q[BUF_W-1 -: 8];
`ifdef RESP_CHECKSUM_EN
      if (cnt_q == 8'd1)
         byte_d = csum_q;
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         buf_q       <= '0;
         cnt_q       <= '0;
         guard_q     <= '0;
         txd_start_q <= 1'b0;
         txd_data_q  <= '0;
         done_q      <= 1'b0;
`ifdef RESP_CHECKSUM_EN
         csum_q      <= '0;
`endif
      end else begin
         txd_start_q <= 1'b0;
         done_q      <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (resp_valid) begin
                  // With uart_tx idle, the code byte is launched straight from
                  // the accept cycle so the first start follows acceptance by
                  // one cycle; otherwise the record waits in SEND.
                  if (!txd_busy) begin
                     txd_start_q <= 1'b1;
                     txd_data_q  <= resp_code;
                     buf_q       <= {cap_d[BUF_W-9:0], 8'h00};
                     cnt_q       <= len_d - 8'd1;
                     guard_q     <= 8'(GUARD_CYCLES - 1);
                     state_q     <= S_GUARD;
`ifdef RESP_CHECKSUM_EN
                     csum_q      <= resp_code;
`endif
                  end else begin
                     buf_q       <= cap_d;
                     cnt_q       <= len_d;
                     state_q     <= S_SEND;
`ifdef RESP_CHECKSUM_EN
                     csum_q      <= '0;
`endif
                  end
               end
            end
            S_SEND: begin
               if (!txd_busy) begin
                  txd_start_q <= 1'b1;
                  txd_data_q  <= byte_d;
                  buf_q       <= {buf_q[BUF_W-9:0], 8'h00};
                  cnt_q       <= cnt_q - 8'd1;
                  guard_q     <= 8'(GUARD_CYCLES - 1);
                  state_q     <= S_GUARD;
`ifdef RESP_CHECKSUM_EN
                  csum_q      <= csum_q ^ byte_d;
`endif
               end
            end
            S_GUARD: begin
               // uart_tx raises busy a cycle after it sees start
               if (guard_q == 8'd0)
                  state_q <= S_WAIT;
               else
                  guard_q <= guard_q - 8'd1;
            end
            S_WAIT: begin
               if (!txd_busy) begin
                  if (cnt_q != 8'd0) begin
                     state_q <= S_SEND;
                  end else begin
                     done_q  <= 1'b1;
                     state_q <= S_IDLE;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cmd_resp_tx.sv
// -----------------------------------------------------------------------------
// tb_cmd_resp_tx
//   Scoreboard bench for cmd_resp_tx: expected frame bytes are queued when a
//   record is offered and popped as txd_start strobes appear. A small uart_tx
//   model raises busy one cycle after each start and holds it a few cycles.
// -----------------------------------------------------------------------------
module tb_cmd_resp_tx;
   import cmd_resp_tx_pkg::*;

   localparam int unsigned SB    = 19;
   localparam int unsigned STR_W = 8 * SB;
   localparam int unsigned BUSY_LEN = 3;

   logic             clk = 1'b0;
   logic             reset;
   logic             resp_valid;
   logic             resp_ready;
   logic [7:0]       resp_code;
   logic             resp_has_payload;
   logic [15:0]      resp_pos;
   logic [STR_W-1:0] resp_str;
   logic             txd_busy;
   logic             txd_start;
   logic [7:0]       txd_data;
   logic             resp_done;

   logic             uart_busy = 1'b0;
   logic             force_busy;
   assign txd_busy = uart_busy | force_busy;

   cmd_resp_tx #(.STR_BYTES(SB), .GUARD_CYCLES(1)) dut (
      .clk              (clk),
      .reset            (reset),
      .resp_valid       (resp_valid),
      .resp_ready       (resp_ready),
      .resp_code        (resp_code),
      .resp_has_payload (resp_has_payload),
      .resp_pos         (resp_pos),
      .resp_str         (resp_str),
      .txd_busy         (txd_busy),
      .txd_start        (txd_start),
      .txd_data         (txd_data),
      .resp_done        (resp_done)
   );

   always #5 clk = ~clk;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   logic [7:0]  exp_q[$];
   int unsigned done_cnt = 0;
   int unsigned done_exp = 0;
   int unsigned bytes_seen = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // uart_tx model and output monitor
   logic        prev_start = 1'b0;
   logic        pend = 1'b0;
   int unsigned busy_cnt = 0;
   always @(negedge clk) begin
      if (busy_cnt != 0) begin
         busy_cnt--;
         if (busy_cnt == 0) uart_busy = 1'b0;
      end
      if (pend) begin
         uart_busy = 1'b1;
         busy_cnt  = BUSY_LEN;
         pend      = 1'b0;
      end
      if (!reset) begin
         if (txd_start) begin
            check_eq("start_while_busy", {31'd0, txd_busy}, 0);
            check_eq("start_back2back", {31'd0, prev_start}, 0);
            check_eq("ready_in_frame", {31'd0, resp_ready}, 0);
            if (exp_q.size() == 0)
               check_eq("unexpected_byte", {24'd0, txd_data}, 32'hFFFF_FFFF);
            else
               check_eq("frame_byte", {24'd0, txd_data}, {24'd0, exp_q.pop_front()});
            bytes_seen++;
            pend = 1'b1;
         end
         if (resp_done) done_cnt++;
      end
      prev_start = txd_start;
   end

   task automatic send_rec(input logic [7:0] code, input logic pl,
                           input logic [15:0] pos, input logic [STR_W-1:0] str);
      int unsigned n;
      logic [7:0]  x;
      logic [7:0]  b;
      logic        was_busy;
      n = 0;
      while (!resp_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (!resp_ready) check_eq("ready_timeout", 0, 1);
      resp_valid       = 1'b1;
      resp_code        = code;
      resp_has_payload = pl;
      resp_pos         = pos;
      resp_str         = str;
      exp_q.push_back(code);
      x = code;
      if (pl) begin
         exp_q.push_back(pos[15:8]);
         exp_q.push_back(pos[7:0]);
         x = x ^ pos[15:8] ^ pos[7:0];
         for (int i = SB - 1; i >= 0; i--) begin
            b = str[8*i +: 8];
            exp_q.push_back(b);
            x = x ^ b;
         end
      end
`ifdef RESP_CHECKSUM_EN
      exp_q.push_back(x);
`endif
      done_exp++;
      #1 was_busy = txd_busy;
      @(negedge clk);
      // scramble inputs after the accept edge
      resp_valid       = 1'b0;
      resp_code        = 8'hA5;
      resp_has_payload = ~pl;
      resp_pos         = 16'hDEAD;
      resp_str         = {STR_W{1'b1}};
      if (!was_busy) check_eq("first_start_lat", {31'd0, txd_start}, 1);
   endtask

   task automatic wait_all();
      int unsigned n;
      n = 0;
      while (done_cnt != done_exp && n < 4000) begin
         @(negedge clk);
         n++;
      end
      check_eq("frame_done", done_cnt, done_exp);
      check_eq("queue_empty", exp_q.size(), 0);
   endtask

   logic [STR_W-1:0] fox;

   initial begin
      int unsigned n;
      fox              = "The quick brown fox";
      reset            = 1'b1;
      resp_valid       = 1'b0;
      resp_code        = '0;
      resp_has_payload = 1'b0;
      resp_pos         = '0;
      resp_str         = '0;
      force_busy       = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_txd_start", {31'd0, txd_start}, 0);
      check_eq("rst_txd_data", {24'd0, txd_data}, 0);
      check_eq("rst_resp_done", {31'd0, resp_done}, 0);
      check_eq("rst_resp_ready", {31'd0, resp_ready}, 1);
      reset = 1'b0;
      @(negedge clk);

      // single code byte, no payload
      send_rec(ACK_OK, 1'b0, 16'h0000, '0);
      wait_all();

      // full payload frame
      send_rec(ACK_MATCH, 1'b1, 16'h0004, fox);
      wait_all();

      // busy held high across accept
      force_busy = 1'b1;
      send_rec(ACK_OK, 1'b0, 16'h0000, '0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check_eq("start_under_busy", {31'd0, txd_start}, 0);
      end
      force_busy = 1'b0;
      @(negedge clk);
      check_eq("start_after_busy", {31'd0, txd_start}, 1);
      wait_all();

      // reset after the fifth byte of a payload frame
      bytes_seen = 0;
      send_rec(ACK_MATCH, 1'b1, 16'h0004, fox);
      n = 0;
      while (bytes_seen < 5 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check_eq("five_bytes_seen", bytes_seen, 5);
      #2 reset = 1'b1;
      #1;
      check_eq("abort_txd_start", {31'd0, txd_start}, 0);
      check_eq("abort_ready", {31'd0, resp_ready}, 1);
      exp_q.delete();
      done_exp--;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (8) @(negedge clk);
      check_eq("no_done_after_abort", done_cnt, done_exp);
      send_rec(8'h3C, 1'b0, 16'h0000, '0);
      wait_all();

      // back-to-back records
      send_rec(ACK_OK, 1'b0, 16'h0000, '0);
      send_rec(ACK_MATCH, 1'b1, 16'h1234, fox);
      wait_all();

      // random payload records
      for (int k = 0; k < 3; k++) begin
         logic [STR_W-1:0] s;
         for (int j = 0; j < int'(SB); j++) s[8*j +: 8] = 8'($urandom);
         send_rec(8'($urandom), 1'($urandom), 16'($urandom), s);
      end
      wait_all();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
